product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 136 +++++++++++++
 tb/tb_product_accumulator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator
//    Sums a group of unsigned 16-bit products from an upstream multiplier
//    stage. A group ends on in_last or after MAX_BEATS products. The
//    group result is then held on the output until the downstream side
//    accepts it. Sums that do not fit saturate to all ones and set a
//    sticky overflow flag for that group.
//
// Ports
//    clk        single clock, rising edge
//    aclr       asynchronous active-high clear
//    flush      synchronous abort of the current group (beats transfers)
//    in_valid   upstream product valid
//    in_ready   product accepted when in_valid is also high
//    in_data    16-bit unsigned product
//    in_last    final product of the group, sampled with in_data
//    out_valid  group result available
//    out_ready  downstream accepts the result
//    out_data   accumulated (possibly saturated) sum
//    out_count  number of products in the sum
//    out_ovf    sum saturated during this group
//
// States
//    state | meaning
//    IDLE  | no group open; the next product starts a new group
//    ACCUM | group open; adding products until last or MAX_BEATS
//    HOLD  | result presented; waiting for out_ready

module product_accumulator #(
   parameter int ACC_WIDTH = 24,
   parameter int MAX_BEATS = 8
) (
   input  logic                 clk,
   input  logic                 aclr,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [15:0]          in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic [3:0]           out_count,
   output logic                 out_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BEATS);

   state_t               state;
   logic [ACC_WIDTH-1:0] acc;
   logic [3:0]           count;
   logic                 ovf;

   logic [ACC_WIDTH:0]   sum_ext;
   logic [3:0]           count_nxt;
   logic                 in_take;
   logic                 out_take;

   // One extra bit on the adder exposes the carry that triggers saturation.
   assign sum_ext   = {1'b0, acc} + {{(ACC_WIDTH-15){1'b0}}, in_data};
   assign count_nxt = count + 4'd1;

   // Internal handshakes use the state alone. aclr gating on in_ready only
   // matters while the flops are held in reset, where they ignore these.
   assign in_take  = in_valid & (state != HOLD);
   assign out_take = out_ready & (state == HOLD);

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_take) begin
                  acc   <= ACC_WIDTH'(in_data);
                  count <= 4'd1;
                  ovf   <= 1'b0;
                  if (in_last || (MAX_CNT == 4'd1))
                     state <= HOLD;
                  else
                     state <= ACCUM;
               end
            end
            ACCUM: begin
               if (in_take) begin
                  if (sum_ext[ACC_WIDTH]) begin
                     acc <= '1;
                     ovf <= 1'b1;
                  end else begin
                     acc <= sum_ext[ACC_WIDTH-1:0];
                  end
                  count <= count_nxt;
                  if (in_last || (count_nxt == MAX_CNT))
                     state <= HOLD;
               end
            end
            HOLD: begin
               if (out_take) begin
                  state <= IDLE;
                  acc   <= '0;
                  count <= '0;
                  ovf   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               acc   <= '0;
               count <= '0;
               ovf   <= 1'b0;
            end
         endcase
      end
   end

   // Outputs are pure decodes of registered state; result fields are
   // forced to zero outside HOLD so partial sums never leak downstream.
   assign in_ready  = ~aclr & (state != HOLD);
   assign out_valid = (state == HOLD);
   assign out_data  = out_valid ? acc   : '0;
   assign out_count = out_valid ? count : 4'd0;
   assign out_ovf   = out_valid & ovf;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

   localparam int W0 = 24;
   localparam int W1 = 17;
   localparam int MB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          aclr, flush, in_valid, in_last, out_ready;
   logic [15:0]   in_data;
   logic [1:0]    rdy, ov, ovf;
   logic [3:0]    oc0, oc1;
   logic [W0-1:0] od0;
   logic [W1-1:0] od1;

   product_accumulator #(.ACC_WIDTH(W0), .MAX_BEATS(MB)) dut0 (
      .clk(clk), .aclr(aclr), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_data(in_data), .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od0), .out_count(oc0), .out_ovf(ovf[0]));

   product_accumulator #(.ACC_WIDTH(W1), .MAX_BEATS(MB)) dut1 (
      .clk(clk), .aclr(aclr), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_data(in_data), .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od1), .out_count(oc1), .out_ovf(ovf[1]));

   int n_vec = 0;
   int n_err = 0;

   // Reference: per-DUT exact group sum, product count, and whether a
   // finished result is waiting. Saturation is applied only when reading.
   bit     m_hold [2];
   int     m_cnt  [2];
   longint m_sum  [2];

   function automatic longint maxv(input int k);
      return (k == 0) ? ((64'sd1 <<< W0) - 1) : ((64'sd1 <<< W1) - 1);
   endfunction

   function automatic logic [63:0] exp_data(input int k);
      if (!m_hold[k]) return 64'd0;
      return (m_sum[k] > maxv(k)) ? 64'(maxv(k)) : 64'(m_sum[k]);
   endfunction

   function automatic logic [3:0] exp_cnt(input int k);
      return m_hold[k] ? 4'(m_cnt[k]) : 4'd0;
   endfunction

   function automatic logic exp_ovf(input int k);
      return m_hold[k] && (m_sum[k] > maxv(k));
   endfunction

   function automatic logic [63:0] got_data(input int k);
      return (k == 0) ? 64'(od0) : 64'(od1);
   endfunction

   function automatic logic [3:0] got_cnt(input int k);
      return (k == 0) ? oc0 : oc1;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_hold[k] = 1'b0;
         m_cnt[k]  = 0;
         m_sum[k]  = 0;
      end
   endtask

   // Called at a falling edge: applies one cycle of inputs, advances the
   // model across the rising edge, and returns at the next falling edge.
   task automatic drive_cycle(input bit v, input logic [15:0] d, input bit l,
                              input bit fl, input bit ordy);
      bit xi [2];
      bit xo [2];
      in_valid = v; in_data = d; in_last = l; flush = fl; out_ready = ordy;
      for (int k = 0; k < 2; k++) begin
         xi[k] = v && !m_hold[k];
         xo[k] = ordy && m_hold[k];
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (fl || xo[k]) begin
            m_hold[k] = 1'b0; m_cnt[k] = 0; m_sum[k] = 0;
         end else if (xi[k]) begin
            m_sum[k] += longint'(d);
            m_cnt[k]++;
            if (l || m_cnt[k] == MB) m_hold[k] = 1'b1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      aclr = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if (rdy !== 2'b00) begin n_err++; $display("FAIL reset_in_ready got %b exp 00", rdy); end
      n_vec++; if (ov !== 2'b00) begin n_err++; $display("FAIL reset_out_valid got %b exp 00", ov); end
      n_vec++; if (od0 !== '0 || oc0 !== 4'd0 || ovf !== 2'b00) begin n_err++; $display("FAIL reset_outputs got %h/%h/%b exp 0", od0, oc0, ovf); end
      aclr = 1'b0;
      model_clear();
      #1;
      n_vec++; if (rdy !== 2'b11) begin n_err++; $display("FAIL reset_release_ready got %b exp 11", rdy); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      drive_cycle(1, 16'd100, 0, 0, 1);
      n_vec++; if (ov[0] !== 1'b0 || od0 !== '0) begin n_err++; $display("FAIL basic_partial got v=%b d=%h exp v=0 d=0", ov[0], od0); end
      drive_cycle(1, 16'd200, 0, 0, 1);
      drive_cycle(1, 16'd300, 1, 0, 1);
      n_vec++; if (ov !== 2'b11) begin n_err++; $display("FAIL basic_valid got %b exp 11", ov); end
      n_vec++; if (od0 !== 24'd600 || od1 !== 17'd600) begin n_err++; $display("FAIL basic_data got %0d/%0d exp 600", od0, od1); end
      n_vec++; if (oc0 !== 4'd3 || ovf[0] !== 1'b0) begin n_err++; $display("FAIL basic_cnt_ovf got %0d/%b exp 3/0", oc0, ovf[0]); end
      drive_cycle(0, 16'd0, 0, 0, 1);
      n_vec++; if (ov !== 2'b00 || od0 !== '0) begin n_err++; $display("FAIL basic_one_cycle got v=%b d=%h exp v=00 d=0", ov, od0); end
   endtask

   task automatic test_max_beats();
      for (int i = 0; i < MB; i++) begin
         drive_cycle(1, 16'hFFFF, 0, 0, 0);
         if (i == MB - 2) begin
            n_vec++; if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL max_before_last got %b exp 1", rdy[0]); end
         end
      end
      n_vec++; if (ov !== 2'b11) begin n_err++; $display("FAIL max_hold got %b exp 11", ov); end
      n_vec++; if (od0 !== 24'h07FFF8 || oc0 !== 4'd8 || ovf[0] !== 1'b0) begin n_err++; $display("FAIL max_w24 got %h/%0d/%b exp 07fff8/8/0", od0, oc0, ovf[0]); end
      n_vec++; if (od1 !== 17'h1FFFF || oc1 !== 4'd8 || ovf[1] !== 1'b1) begin n_err++; $display("FAIL max_w17 got %h/%0d/%b exp 1ffff/8/1", od1, oc1, ovf[1]); end
      drive_cycle(0, 16'd0, 0, 0, 1);
      n_vec++; if (ov !== 2'b00) begin n_err++; $display("FAIL max_drain got %b exp 00", ov); end
   endtask

   task automatic test_saturate();
      drive_cycle(1, 16'hFFFF, 0, 0, 0);
      drive_cycle(1, 16'hFFFF, 0, 0, 0);
      drive_cycle(1, 16'h0005, 1, 0, 0);
      n_vec++; if (od1 !== 17'h1FFFF || ovf[1] !== 1'b1 || oc1 !== 4'd3) begin n_err++; $display("FAIL sat_w17 got %h/%b/%0d exp 1ffff/1/3", od1, ovf[1], oc1); end
      n_vec++; if (od0 !== 24'h020003 || ovf[0] !== 1'b0) begin n_err++; $display("FAIL sat_w24 got %h/%b exp 020003/0", od0, ovf[0]); end
      drive_cycle(0, 16'd0, 0, 0, 1);
      drive_cycle(1, 16'd4, 1, 0, 0);
      n_vec++; if (ovf[1] !== 1'b0 || od1 !== 17'd4) begin n_err++; $display("FAIL sat_cleared got %b/%h exp 0/4", ovf[1], od1); end
      drive_cycle(0, 16'd0, 0, 0, 1);
   endtask

   task automatic test_backpressure();
      drive_cycle(1, 16'd1, 0, 0, 0);
      drive_cycle(1, 16'd2, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1, 16'd9, 1, 0, 0);
         n_vec++; if (rdy !== 2'b00 || ov[0] !== 1'b1 || od0 !== 24'd3) begin n_err++; $display("FAIL bp_hold%0d got r=%b v=%b d=%0d exp r=00 v=1 d=3", i, rdy, ov[0], od0); end
      end
      drive_cycle(1, 16'd9, 1, 0, 1);
      n_vec++; if (ov !== 2'b00 || rdy !== 2'b11) begin n_err++; $display("FAIL bp_release got v=%b r=%b exp 00/11", ov, rdy); end
      drive_cycle(1, 16'd9, 1, 0, 1);
      n_vec++; if (ov[0] !== 1'b1 || od0 !== 24'd9 || oc0 !== 4'd1) begin n_err++; $display("FAIL bp_next got v=%b d=%0d c=%0d exp 1/9/1", ov[0], od0, oc0); end
      drive_cycle(0, 16'd0, 0, 0, 1);
   endtask

   task automatic test_flush();
      drive_cycle(1, 16'd11, 0, 0, 0);
      drive_cycle(1, 16'd12, 0, 0, 0);
      drive_cycle(1, 16'd13, 0, 1, 0);
      n_vec++; if (ov !== 2'b00 || rdy !== 2'b11 || od0 !== '0 || oc0 !== 4'd0) begin n_err++; $display("FAIL flush_idle got v=%b r=%b d=%0d exp 00/11/0", ov, rdy, od0); end
      drive_cycle(1, 16'd7, 0, 0, 0);
      drive_cycle(1, 16'd8, 1, 0, 0);
      n_vec++; if (od0 !== 24'd15 || oc0 !== 4'd2 || ov[0] !== 1'b1) begin n_err++; $display("FAIL flush_next got d=%0d c=%0d v=%b exp 15/2/1", od0, oc0, ov[0]); end
      drive_cycle(1, 16'd3, 1, 1, 1);
      n_vec++; if (ov !== 2'b00 || od0 !== '0) begin n_err++; $display("FAIL flush_hold got v=%b d=%0d exp 00/0", ov, od0); end
   endtask

   task automatic test_aclr();
      drive_cycle(1, 16'd50, 0, 0, 0);
      drive_cycle(1, 16'd60, 0, 0, 0);
      #2 aclr = 1'b1;
      #1;
      n_vec++; if (rdy !== 2'b00 || ov !== 2'b00 || od0 !== '0 || oc0 !== 4'd0) begin n_err++; $display("FAIL aclr_accum got r=%b v=%b d=%0d exp 00/00/0", rdy, ov, od0); end
      #1 aclr = 1'b0;
      model_clear();
      @(negedge clk);
      n_vec++; if (rdy !== 2'b11 || ov !== 2'b00) begin n_err++; $display("FAIL aclr_accum_after got r=%b v=%b exp 11/00", rdy, ov); end
      drive_cycle(1, 16'd5, 1, 0, 0);
      n_vec++; if (ov[0] !== 1'b1 || od0 !== 24'd5) begin n_err++; $display("FAIL aclr_pre_hold got v=%b d=%0d exp 1/5", ov[0], od0); end
      #2 aclr = 1'b1;
      #1;
      n_vec++; if (ov !== 2'b00 || od0 !== '0 || oc0 !== 4'd0 || ovf !== 2'b00) begin n_err++; $display("FAIL aclr_hold got v=%b d=%0d c=%0d exp 0", ov, od0, oc0); end
      #1 aclr = 1'b0;
      model_clear();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(0, 16'd0, 0, 0, 1);
         n_vec++; if (ov !== 2'b00) begin n_err++; $display("FAIL aclr_spurious%0d got %b exp 00", i, ov); end
      end
      drive_cycle(1, 16'd4, 1, 0, 0);
      n_vec++; if (od0 !== 24'd4 || oc0 !== 4'd1) begin n_err++; $display("FAIL aclr_restart got d=%0d c=%0d exp 4/1", od0, oc0); end
      drive_cycle(0, 16'd0, 0, 0, 1);
   endtask

   task automatic test_random();
      bit          v, l, fl, ordy;
      logic [15:0] d;
      for (int i = 0; i < 400; i++) begin
         v    = ($urandom_range(0, 3) != 0);
         d    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         l    = ($urandom_range(0, 4) == 0);
         fl   = ($urandom_range(0, 29) == 0);
         ordy = ($urandom_range(0, 2) != 0);
         drive_cycle(v, d, l, fl, ordy);
         for (int k = 0; k < 2; k++) begin
            n_vec++; if (ov[k] !== m_hold[k]) begin n_err++; $display("FAIL rnd_valid dut%0d cyc %0d got %b exp %b", k, i, ov[k], m_hold[k]); end
            n_vec++; if (rdy[k] !== !m_hold[k]) begin n_err++; $display("FAIL rnd_ready dut%0d cyc %0d got %b exp %b", k, i, rdy[k], !m_hold[k]); end
            n_vec++; if (got_data(k) !== exp_data(k)) begin n_err++; $display("FAIL rnd_data dut%0d cyc %0d got %h exp %h", k, i, got_data(k), exp_data(k)); end
            n_vec++; if (got_cnt(k) !== exp_cnt(k)) begin n_err++; $display("FAIL rnd_count dut%0d cyc %0d got %0d exp %0d", k, i, got_cnt(k), exp_cnt(k)); end
            n_vec++; if (ovf[k] !== exp_ovf(k)) begin n_err++; $display("FAIL rnd_ovf dut%0d cyc %0d got %b exp %b", k, i, ovf[k], exp_ovf(k)); end
         end
      end
   endtask

   initial begin
      aclr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b0; in_data = 16'd0;
      model_clear();
      test_reset();
      test_basic();
      test_max_beats();
      test_saturate();
      test_backpressure();
      test_flush();
      test_aclr();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
